// File: rtl/add_node_scheduler_if.sv
// Gene memory read port and output gene memory write port of the add-node scheduler.
interface add_node_scheduler_if #(
  parameter int GENE_SZ = 64,
  parameter int ADDR_SZ = 10
);
  logic               rd_en;
  logic [ADDR_SZ-1:0] rd_addr;
  logic [GENE_SZ-1:0] rd_data;
  logic               wr_en;
  logic [ADDR_SZ-1:0] wr_addr;
  logic [GENE_SZ-1:0] wr_data;
  logic               wr_ready;

  modport master (
    output rd_en, rd_addr, input rd_data,
    output wr_en, wr_addr, wr_data, input wr_ready
  );

  modport slave (
    input rd_en, rd_addr, output rd_data,
    input wr_en, wr_addr, wr_data, output wr_ready
  );
endinterface

// File: rtl/add_node_scheduler.sv
// Add-node mutation lane sequencer: streams one genome's genes through the lane,
// limits the genome to a single add-node mutation, and drains the lane's 1- or
// 3-gene result into the output gene memory under write backpressure.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for start; results of the last run held
// READ    | gene memory read strobe for gene idx
// WAIT    | read data returning; registered into lane_gene on exit
// FEED    | lane_state presented to the lane (mutate or pass)
// CAPTURE | lane result captured into the 3-entry buffer
// DRAIN   | buffered genes written in order out1, out2, out3
// DONE    | one-cycle done pulse, then back to IDLE
module add_node_scheduler #(
  parameter int GENE_SZ = 64,
  parameter int ATTR_SZ = 8,
  parameter int ADDR_SZ = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ATTR_SZ-1:0] genome_id,
  input  logic [ADDR_SZ-1:0] gene_base,
  input  logic [ADDR_SZ-1:0] out_base,
  input  logic [ADDR_SZ-1:0] gene_count,
  input  logic [ATTR_SZ-1:0] node_add_prob,
  input  logic [ATTR_SZ-1:0] random,
  output logic               busy,
  output logic               done,
  output logic [ADDR_SZ-1:0] out_count,
  output logic               mutated,
  add_node_scheduler_if.master mem,
  output logic [1:0]         lane_state,
  output logic [GENE_SZ-1:0] lane_gene,
  output logic [ATTR_SZ-1:0] lane_prob,
  output logic [ATTR_SZ-1:0] lane_random,
  output logic [ATTR_SZ-1:0] lane_genome_id,
  input  logic [GENE_SZ-1:0] lane_gene_out1,
  input  logic [GENE_SZ-1:0] lane_gene_out2,
  input  logic [GENE_SZ-1:0] lane_gene_out3,
  input  logic [2:0]         lane_out_valid
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WAIT, S_FEED, S_CAPTURE, S_DRAIN, S_DONE
  } state_t;

  localparam logic [1:0] LANE_MUTATE = 2'b10;
  localparam logic [1:0] LANE_PASS   = 2'b00;
  localparam logic [1:0] LANE_IDLE   = 2'b11;

  state_t             state;
  logic [ADDR_SZ-1:0] gene_base_q, out_base_q, gene_count_q, idx;
  logic [GENE_SZ-1:0] buf_gene [0:2];
  logic [2:0]         buf_valid;
  logic [2:0]         sel_oh;

  logic               accept;
  logic [2:0]         src_valid;
  logic [2:0]         next_oh;
  logic [GENE_SZ-1:0] next_data;
  logic [ADDR_SZ-1:0] out_count_inc;
  logic [ADDR_SZ-1:0] idx_next;

  // Pick the next buffered entry to write: straight from the lane in CAPTURE,
  // from the buffer minus the entry being accepted this cycle in DRAIN.
  always_comb begin
    accept        = mem.wr_en && mem.wr_ready;
    out_count_inc = out_count + ADDR_SZ'(accept);
    idx_next      = idx + 1'b1;
    if (state == S_CAPTURE) src_valid = lane_out_valid;
    else                    src_valid = buf_valid & ~(accept ? sel_oh : 3'b000);
    next_oh   = 3'b000;
    next_data = '0;
    if (src_valid[0]) begin
      next_oh   = 3'b001;
      next_data = (state == S_CAPTURE) ? lane_gene_out1 : buf_gene[0];
    end else if (src_valid[1]) begin
      next_oh   = 3'b010;
      next_data = (state == S_CAPTURE) ? lane_gene_out2 : buf_gene[1];
    end else if (src_valid[2]) begin
      next_oh   = 3'b100;
      next_data = (state == S_CAPTURE) ? lane_gene_out3 : buf_gene[2];
    end
  end

  // Result buffer data; validity is tracked separately in the FSM.
  always_ff @(posedge clk) begin
    if (state == S_CAPTURE) begin
      buf_gene[0] <= lane_gene_out1;
      buf_gene[1] <= lane_gene_out2;
      buf_gene[2] <= lane_gene_out3;
    end
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      out_count      <= '0;
      mutated        <= 1'b0;
      idx            <= '0;
      gene_base_q    <= '0;
      out_base_q     <= '0;
      gene_count_q   <= '0;
      buf_valid      <= 3'b000;
      sel_oh         <= 3'b000;
      mem.rd_en      <= 1'b0;
      mem.rd_addr    <= '0;
      mem.wr_en      <= 1'b0;
      mem.wr_addr    <= '0;
      mem.wr_data    <= '0;
      lane_state     <= LANE_IDLE;
      lane_gene      <= '0;
      lane_random    <= '0;
      lane_prob      <= '0;
      lane_genome_id <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            gene_base_q    <= gene_base;
            out_base_q     <= out_base;
            gene_count_q   <= gene_count;
            lane_prob      <= node_add_prob;
            lane_genome_id <= genome_id;
            idx            <= '0;
            out_count      <= '0;
            mutated        <= 1'b0;
            busy           <= 1'b1;
            if (gene_count == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state       <= S_READ;
              mem.rd_en   <= 1'b1;
              mem.rd_addr <= gene_base;
            end
          end
        end
        S_READ: begin
          mem.rd_en <= 1'b0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          lane_gene   <= mem.rd_data;
          lane_random <= random;
          lane_state  <= mutated ? LANE_PASS : LANE_MUTATE;
          state       <= S_FEED;
        end
        S_FEED: begin
          lane_state <= LANE_IDLE;
          state      <= S_CAPTURE;
        end
        S_CAPTURE, S_DRAIN: begin
          if (state == S_CAPTURE && lane_out_valid == 3'b111) mutated <= 1'b1;
          out_count   <= out_count_inc;
          buf_valid   <= src_valid;
          sel_oh      <= next_oh;
          mem.wr_en   <= |src_valid;
          mem.wr_addr <= out_base_q + out_count_inc;
          if (|src_valid) begin
            mem.wr_data <= next_data;
            state       <= S_DRAIN;
          end else if (state == S_CAPTURE) begin
            state <= S_DRAIN;
          end else begin
            idx <= idx_next;
            if (idx_next == gene_count_q) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state       <= S_READ;
              mem.rd_en   <= 1'b1;
              mem.rd_addr <= gene_base_q + idx_next;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
